ball_motion: RTL and testbench

BALL_MOTION -- requirements
Module: ball_motion

---
 rtl/billiard_pkg.sv | 40 ++++
 rtl/frame_divider.sv | 26 ++
 rtl/ball_motion.sv | 172 +++++++++++++++++
 tb/tb_ball_motion.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/billiard_pkg.sv
// Shared fixed-point constants, ball state encoding and saturating arithmetic helpers.
package billiard_pkg;

    localparam int unsigned FIXED_SHIFT = 6;
    localparam int unsigned POS_W       = 17;
    localparam int unsigned VEL_W       = 11;
    localparam int unsigned PIX_W       = POS_W - FIXED_SHIFT;
    localparam int unsigned HOLE_W      = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVING = 2'd1,
        SUNK   = 2'd2
    } ball_state_t;

    // One friction step: magnitude shrinks by one LSB, zero stays zero.
    function automatic logic signed [VEL_W-1:0] step_toward_zero(input logic signed [VEL_W-1:0] v);
        if (v == '0)
            return v;
        else if (v[VEL_W-1])
            return v + VEL_W'(1);
        else
            return v - VEL_W'(1);
    endfunction

    // Clamp a one-bit-wider sum back into the position range instead of wrapping.
    function automatic logic signed [POS_W-1:0] sat_pos(input logic signed [POS_W:0] s);
        if (s[POS_W] != s[POS_W-1])
            return s[POS_W] ? {1'b1, {(POS_W-1){1'b0}}} : {1'b0, {(POS_W-1){1'b1}}};
        return s[POS_W-1:0];
    endfunction

    function automatic logic signed [POS_W-1:0] add_vel(input logic signed [POS_W-1:0] pos,
                                                        input logic signed [VEL_W-1:0] vel);
        logic signed [POS_W:0] sum;
        sum = {pos[POS_W-1], pos} + {{(POS_W+1-VEL_W){vel[VEL_W-1]}}, vel};
        return sat_pos(sum);
    endfunction

endpackage

// File: rtl/frame_divider.sv
// Counts qualifying frame pulses and flags every PERIOD-th one; synchronous clear wins.
module frame_divider #(
    parameter int unsigned PERIOD = 4
) (
    input  logic clk,
    input  logic resetN,
    input  logic clear,
    input  logic pulse,
    output logic tick_c
);

    localparam int unsigned CNT_W = ($clog2(PERIOD + 1) > 3) ? $clog2(PERIOD + 1) : 3;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt;

    assign tick_c = pulse && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!resetN || clear)
            cnt <= '0;
        else if (pulse)
            cnt <= tick_c ? '0 : cnt + CNT_W'(1);
    end

endmodule

// File: rtl/ball_motion.sv
// Per-frame ball kinematics: shot launch, collision/pocket event latching, friction and respawn.
module ball_motion
    import billiard_pkg::*;
#(
    parameter int          INITIAL_X       = 100,
    parameter int          INITIAL_Y       = 200,
    parameter int unsigned FRICTION_PERIOD = 4,
    parameter int          MAX_VEL         = 512
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     startOfFrame,
    input  logic                     collisionOccurred,
    input  logic signed [VEL_W-1:0]  velXIn,
    input  logic signed [VEL_W-1:0]  velYIn,
    input  logic                     holeHit,
    input  logic [HOLE_W-1:0]        holeNum,
    input  logic                     shotValid,
    input  logic signed [VEL_W-1:0]  shotVelX,
    input  logic signed [VEL_W-1:0]  shotVelY,
    input  logic                     respawn,
    output logic signed [PIX_W-1:0]  topLeftX,
    output logic signed [PIX_W-1:0]  topLeftY,
    output logic signed [VEL_W-1:0]  velX,
    output logic signed [VEL_W-1:0]  velY,
    output logic                     moving,
    output logic                     sunk,
    output logic [HOLE_W-1:0]        sunkHoleNum
);

    localparam logic signed [POS_W-1:0] INIT_X = POS_W'(INITIAL_X << FIXED_SHIFT);
    localparam logic signed [POS_W-1:0] INIT_Y = POS_W'(INITIAL_Y << FIXED_SHIFT);
    localparam logic signed [VEL_W-1:0] VMAX   = VEL_W'(MAX_VEL);
    localparam logic signed [VEL_W-1:0] VMIN   = -VMAX;

    function automatic logic signed [VEL_W-1:0] clamp_vel(input logic signed [VEL_W-1:0] v);
        if (v > VMAX)
            return VMAX;
        else if (v < VMIN)
            return VMIN;
        return v;
    endfunction

    ball_state_t              state;
    logic signed [POS_W-1:0]  pos_x, pos_y;
    logic signed [VEL_W-1:0]  vel_x, vel_y;

    logic                     coll_pend, hole_pend, shot_pend;
    logic signed [VEL_W-1:0]  coll_vx, coll_vy, shot_vx, shot_vy;
    logic [HOLE_W-1:0]        hole_latch;

    logic signed [VEL_W-1:0]  base_vx, base_vy, next_vx, next_vy;
    logic signed [POS_W-1:0]  next_px, next_py;
    logic                     stop_c, shot_ok_c, respawn_c;
    logic                     div_pulse_c, div_clear_c, tick_c;

    assign topLeftX = pos_x[POS_W-1:FIXED_SHIFT];
    assign topLeftY = pos_y[POS_W-1:FIXED_SHIFT];
    assign velX     = vel_x;
    assign velY     = vel_y;

    assign shot_ok_c   = shotValid && (state == IDLE) && ((shotVelX != '0) || (shotVelY != '0));
    assign respawn_c   = respawn && (state == SUNK);
    assign div_pulse_c = startOfFrame && (state == MOVING);
    assign div_clear_c = (state != MOVING) || (div_pulse_c && (hole_pend || stop_c));

    frame_divider #(
        .PERIOD (FRICTION_PERIOD)
    ) u_friction (
        .clk    (clk),
        .resetN (resetN),
        .clear  (div_clear_c),
        .pulse  (div_pulse_c),
        .tick_c (tick_c)
    );

    // Frame update datapath: choose the loaded velocity, move with it, then apply friction.
    always_comb begin
        base_vx = vel_x;
        base_vy = vel_y;
        if (state == IDLE) begin
            base_vx = clamp_vel(shot_vx);
            base_vy = clamp_vel(shot_vy);
        end else if (coll_pend) begin
            base_vx = clamp_vel(coll_vx);
            base_vy = clamp_vel(coll_vy);
        end
        next_px = add_vel(pos_x, base_vx);
        next_py = add_vel(pos_y, base_vy);
        next_vx = tick_c ? step_toward_zero(base_vx) : base_vx;
        next_vy = tick_c ? step_toward_zero(base_vy) : base_vy;
        stop_c  = (next_vx == '0) && (next_vy == '0);
    end

    always_ff @(posedge clk) begin
        if (!resetN || respawn_c) begin
            state       <= IDLE;
            pos_x       <= INIT_X;
            pos_y       <= INIT_Y;
            vel_x       <= '0;
            vel_y       <= '0;
            moving      <= 1'b0;
            sunk        <= 1'b0;
            sunkHoleNum <= '0;
            coll_pend   <= 1'b0;
            hole_pend   <= 1'b0;
            shot_pend   <= 1'b0;
            coll_vx     <= '0;
            coll_vy     <= '0;
            shot_vx     <= '0;
            shot_vy     <= '0;
            hole_latch  <= '0;
        end else begin
            // Event latches: frame boundary consumes them and opens a fresh window.
            if (startOfFrame) begin
                coll_pend <= collisionOccurred;
                hole_pend <= holeHit;
                shot_pend <= shot_ok_c;
            end else begin
                if (collisionOccurred) coll_pend <= 1'b1;
                if (holeHit)           hole_pend <= 1'b1;
                if (shot_ok_c)         shot_pend <= 1'b1;
            end
            if (collisionOccurred && (startOfFrame || !coll_pend)) begin
                coll_vx <= velXIn;
                coll_vy <= velYIn;
            end
            if (holeHit && (startOfFrame || !hole_pend))
                hole_latch <= holeNum;
            if (shot_ok_c && (startOfFrame || !shot_pend)) begin
                shot_vx <= shotVelX;
                shot_vy <= shotVelY;
            end

            if (startOfFrame) begin
                case (state)
                    IDLE: begin
                        if (shot_pend) begin
                            state  <= MOVING;
                            moving <= 1'b1;
                            pos_x  <= next_px;
                            pos_y  <= next_py;
                            vel_x  <= next_vx;
                            vel_y  <= next_vy;
                        end
                    end
                    MOVING: begin
                        if (hole_pend) begin
                            state       <= SUNK;
                            moving      <= 1'b0;
                            sunk        <= 1'b1;
                            sunkHoleNum <= hole_latch;
                            vel_x       <= '0;
                            vel_y       <= '0;
                        end else begin
                            pos_x <= next_px;
                            pos_y <= next_py;
                            vel_x <= next_vx;
                            vel_y <= next_vy;
                            if (stop_c) begin
                                state  <= IDLE;
                                moving <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ball_motion.sv
// Directed and randomized checks of ball_motion against a frame-level behavioural model.
module tb_ball_motion;

    localparam int IX = 100;
    localparam int IY = 200;
    localparam int FP = 4;
    localparam int MV = 512;
    localparam int ST_IDLE = 0;
    localparam int ST_MOV  = 1;
    localparam int ST_SUNK = 2;

    logic               clk = 1'b0;
    logic               resetN;
    logic               startOfFrame, collisionOccurred, holeHit, shotValid, respawn;
    logic signed [10:0] velXIn, velYIn, shotVelX, shotVelY;
    logic [2:0]         holeNum;
    logic signed [10:0] topLeftX, topLeftY, velX, velY;
    logic               moving, sunk;
    logic [2:0]         sunkHoleNum;

    ball_motion #(
        .INITIAL_X       (IX),
        .INITIAL_Y       (IY),
        .FRICTION_PERIOD (FP),
        .MAX_VEL         (MV)
    ) dut (
        .clk               (clk),
        .resetN            (resetN),
        .startOfFrame      (startOfFrame),
        .collisionOccurred (collisionOccurred),
        .velXIn            (velXIn),
        .velYIn            (velYIn),
        .holeHit           (holeHit),
        .holeNum           (holeNum),
        .shotValid         (shotValid),
        .shotVelX          (shotVelX),
        .shotVelY          (shotVelY),
        .respawn           (respawn),
        .topLeftX          (topLeftX),
        .topLeftY          (topLeftY),
        .velX              (velX),
        .velY              (velY),
        .moving            (moving),
        .sunk              (sunk),
        .sunkHoleNum       (sunkHoleNum)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference model state: position in 1/64 px, velocity in 1/64 px/frame.
    int m_state, m_px, m_py, m_vx, m_vy, m_fc, m_hole_out;
    int m_coll, m_cvx, m_cvy, m_hole, m_hn, m_shot, m_svx, m_svy;

    function automatic int clampv(input int v);
        return (v > MV) ? MV : ((v < -MV) ? -MV : v);
    endfunction

    function automatic int satp(input int p);
        return (p > 65535) ? 65535 : ((p < -65536) ? -65536 : p);
    endfunction

    function automatic int tz(input int v);
        return (v > 0) ? v - 1 : ((v < 0) ? v + 1 : 0);
    endfunction

    task automatic model_reset();
        m_state = ST_IDLE; m_px = IX * 64; m_py = IY * 64;
        m_vx = 0; m_vy = 0; m_fc = 0; m_hole_out = 0;
        m_coll = 0; m_cvx = 0; m_cvy = 0; m_hole = 0; m_hn = 0;
        m_shot = 0; m_svx = 0; m_svy = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int shot_ok;
        if (!resetN || (respawn && m_state == ST_SUNK)) begin
            model_reset();
            return;
        end
        shot_ok = (shotValid && m_state == ST_IDLE && (shotVelX != 0 || shotVelY != 0)) ? 1 : 0;
        if (startOfFrame) begin
            if (m_state == ST_IDLE && m_shot != 0) begin
                m_vx = clampv(m_svx); m_vy = clampv(m_svy);
                m_px = satp(m_px + m_vx); m_py = satp(m_py + m_vy);
                m_state = ST_MOV;
            end else if (m_state == ST_MOV) begin
                if (m_hole != 0) begin
                    m_state = ST_SUNK; m_vx = 0; m_vy = 0; m_hole_out = m_hn; m_fc = 0;
                end else begin
                    if (m_coll != 0) begin
                        m_vx = clampv(m_cvx); m_vy = clampv(m_cvy);
                    end
                    m_px = satp(m_px + m_vx); m_py = satp(m_py + m_vy);
                    m_fc++;
                    if (m_fc == FP) begin
                        m_fc = 0; m_vx = tz(m_vx); m_vy = tz(m_vy);
                    end
                    if (m_vx == 0 && m_vy == 0) begin
                        m_state = ST_IDLE; m_fc = 0;
                    end
                end
            end
            m_coll = collisionOccurred; m_cvx = int'(velXIn); m_cvy = int'(velYIn);
            m_hole = holeHit; m_hn = int'(holeNum);
            m_shot = shot_ok; m_svx = int'(shotVelX); m_svy = int'(shotVelY);
        end else begin
            if (collisionOccurred && m_coll == 0) begin
                m_coll = 1; m_cvx = int'(velXIn); m_cvy = int'(velYIn);
            end
            if (holeHit && m_hole == 0) begin
                m_hole = 1; m_hn = int'(holeNum);
            end
            if (shot_ok != 0 && m_shot == 0) begin
                m_shot = 1; m_svx = int'(shotVelX); m_svy = int'(shotVelY);
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "/topLeftX"},    int'(topLeftX),    m_px >>> 6);
        check({tag, "/topLeftY"},    int'(topLeftY),    m_py >>> 6);
        check({tag, "/velX"},        int'(velX),        m_vx);
        check({tag, "/velY"},        int'(velY),        m_vy);
        check({tag, "/moving"},      int'(moving),      (m_state == ST_MOV) ? 1 : 0);
        check({tag, "/sunk"},        int'(sunk),        (m_state == ST_SUNK) ? 1 : 0);
        check({tag, "/sunkHoleNum"}, int'(sunkHoleNum), m_hole_out);
    endtask

    task automatic clear_inputs();
        startOfFrame = 0; collisionOccurred = 0; velXIn = '0; velYIn = '0;
        holeHit = 0; holeNum = '0; shotValid = 0; shotVelX = '0; shotVelY = '0;
        respawn = 0;
    endtask

    // One clock: model advances, DUT clocks, outputs compared after the edge, events dropped.
    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_all(tag);
        clear_inputs();
    endtask

    task automatic frame(input string tag);
        cycle(tag);
        cycle(tag);
        startOfFrame = 1;
        cycle(tag);
    endtask

    task automatic shot(input int vx, input int vy, input string tag);
        shotValid = 1; shotVelX = 11'(vx); shotVelY = 11'(vy);
        cycle(tag);
        startOfFrame = 1;
        cycle(tag);
    endtask

    task automatic do_reset();
        resetN = 0;
        cycle("reset");
        resetN = 1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "/x"},     int'(topLeftX), IX);
        check({tag, "/y"},     int'(topLeftY), IY);
        check({tag, "/vx"},    int'(velX), 0);
        check({tag, "/vy"},    int'(velY), 0);
        check({tag, "/mov"},   int'(moving), 0);
        check({tag, "/sunk"},  int'(sunk), 0);
        check({tag, "/hole"},  int'(sunkHoleNum), 0);
    endtask

    function automatic int rand_vel();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 8)) - 4;
            1:       return int'($urandom_range(0, 2047)) - 1024;
            2:       return int'($urandom_range(0, 200)) - 100;
            default: return 0;
        endcase
    endfunction

    initial begin
        int nf;
        clear_inputs();
        resetN = 0;
        cycle("reset");
        cycle("reset");
        check_reset_values("rst");
        resetN = 1;

        // Launch from rest: one frame of motion at 2 px/frame.
        shot(128, 0, "shot128");
        check("shot128/x", int'(topLeftX), 102);
        check("shot128/vx", int'(velX), 128);
        check("shot128/mov", int'(moving), 1);
        do_reset();

        // Friction brings a slow ball to rest.
        shot(5, 0, "fric");
        nf = 0;
        while (moving && nf < 40) begin
            frame("fric");
            nf++;
            if (nf == 3) check("fric/f3_vx", int'(velX), 5);
            if (nf == 4) check("fric/f4_vx", int'(velX), 4);
        end
        check("fric/frames_to_stop", nf, 20);
        check("fric/vx_end", int'(velX), 0);
        check("fric/mov_end", int'(moving), 0);
        do_reset();

        // Only the first collision in a frame takes effect.
        shot(100, 50, "coll");
        collisionOccurred = 1; velXIn = -11'sd100; velYIn = 11'sd50;
        cycle("coll");
        collisionOccurred = 1; velXIn = 11'sd7; velYIn = 11'sd7;
        cycle("coll");
        startOfFrame = 1;
        cycle("coll");
        check("coll/vx", int'(velX), -100);
        check("coll/vy", int'(velY), 50);

        // Pocket beats collision in the same frame, then respawn.
        collisionOccurred = 1; velXIn = 11'sd30; velYIn = 11'sd30;
        holeHit = 1; holeNum = 3'd3;
        cycle("sink");
        startOfFrame = 1;
        cycle("sink");
        check("sink/sunk", int'(sunk), 1);
        check("sink/hole", int'(sunkHoleNum), 3);
        check("sink/vx", int'(velX), 0);
        check("sink/mov", int'(moving), 0);
        frame("sunk_frozen");
        respawn = 1;
        cycle("respawn");
        check_reset_values("respawn");

        // Saturated launch runs into the position limits, then reset mid-motion.
        shot(1023, -1024, "sat");
        check("sat/vx", int'(velX), 512);
        check("sat/vy", int'(velY), -512);
        repeat (170) frame("sat");
        check("sat/x_limit", int'(topLeftX), 1023);
        check("sat/y_limit", int'(topLeftY), -1024);
        collisionOccurred = 1; velXIn = 11'sd9; velYIn = 11'sd9;
        cycle("midrst");
        resetN = 0;
        cycle("midrst");
        check_reset_values("midrst");
        resetN = 1;
        startOfFrame = 1;
        cycle("after_rst");
        check("after_rst/mov", int'(moving), 0);

        // Randomized traffic against the model.
        repeat (1500) begin
            resetN            = ($urandom_range(0, 299) != 0);
            startOfFrame      = ($urandom_range(0, 3) == 0);
            collisionOccurred = ($urandom_range(0, 5) == 0);
            velXIn            = 11'(rand_vel());
            velYIn            = 11'(rand_vel());
            holeHit           = ($urandom_range(0, 49) == 0);
            holeNum           = 3'($urandom_range(1, 6));
            shotValid         = ($urandom_range(0, 5) == 0);
            shotVelX          = 11'(rand_vel());
            shotVelY          = 11'(rand_vel());
            respawn           = ($urandom_range(0, 24) == 0);
            cycle("rand");
        end
        resetN = 1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
